// File: rtl/backprop_seq_if.sv
// Request/response bundle between the neuron weight store, the back-propagation engine
// and the previous layer's error accumulator.
interface backprop_seq_if #(
  parameter int N_INPUTS = 32,
  parameter int DATA_W   = 16
);
  logic                           in_valid;
  logic                           in_ready;
  logic [N_INPUTS*DATA_W-1:0]     dendrites;
  logic [(N_INPUTS+1)*DATA_W-1:0] weights;
  logic [DATA_W-1:0]              axon;
  logic [DATA_W-1:0]              backprop;
  logic [DATA_W-1:0]              training_ratio;
  logic                           out_valid;
  logic                           out_ready;
  logic [N_INPUTS*DATA_W-1:0]     backprop_change;
  logic [(N_INPUTS+1)*DATA_W-1:0] weights_new;
  logic                           busy;

  modport master (
    output in_valid, dendrites, weights, axon, backprop, training_ratio, out_ready,
    input  in_ready, out_valid, backprop_change, weights_new, busy
  );

  modport slave (
    input  in_valid, dendrites, weights, axon, backprop, training_ratio, out_ready,
    output in_ready, out_valid, backprop_change, weights_new, busy
  );
endinterface

// File: rtl/backprop_seq_engine.sv
// Sequential fixed-point back-propagation for one neuron: derivative, delta, then one weight per cycle.
// out_valid N_INPUTS+3 edges after accept; accepts only when idle, results held until out_ready.
module backprop_seq_engine #(
  parameter int N_INPUTS = 32,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 12
) (
  input logic           clk,
  input logic           rst,
  backprop_seq_if.slave bus
);
  localparam int IDX_W  = $clog2(N_INPUTS + 1);
  localparam int WIDE_W = 2*DATA_W + 2;

  typedef logic signed [DATA_W-1:0] word_t;
  typedef logic signed [WIDE_W-1:0] wide_t;

  localparam wide_t SAT_MAX = (wide_t'(1) <<< (DATA_W-1)) - wide_t'(1);
  localparam wide_t SAT_MIN = -(wide_t'(1) <<< (DATA_W-1));
  localparam word_t ONE     = word_t'(1) <<< FRAC_W;

  typedef enum logic [2:0] {S_IDLE, S_DERIV, S_DELTA, S_UPDATE, S_DONE} state_t;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [N_INPUTS-1:0][DATA_W-1:0] dend_q, dend_d, change_q, change_d;
  logic [N_INPUTS:0][DATA_W-1:0]   w_q, w_d, w_new_q, w_new_d;
  word_t axon_q, axon_d, bp_q, bp_d, ratio_q, ratio_d;
  word_t d_q, d_d, delta_q, delta_d, step_q, step_d;

  word_t w_sel, dend_sel, lane1_s, lane2_s;
  wide_t lane1_a, lane1_b, lane1_p, lane2_a, lane2_b, lane2_p, w_sum;

  function automatic word_t sat(input wide_t v);
    if (v > SAT_MAX) return word_t'(SAT_MAX);
    if (v < SAT_MIN) return word_t'(SAT_MIN);
    return word_t'(v);
  endfunction

  // Two multiplier lanes shared across phases; the bias slot sees a constant ONE input.
  always_comb begin
    w_sel    = w_q[N_INPUTS];
    dend_sel = ONE;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_sel    = w_q[i];
        dend_sel = dend_q[i];
      end
    end

    lane1_a = wide_t'(bp_q);
    lane1_b = wide_t'(d_q);
    case (state_q)
      S_DERIV: begin
        lane1_a = wide_t'(axon_q);
        lane1_b = wide_t'(ONE) - wide_t'(axon_q);
      end
      S_UPDATE: begin
        lane1_a = wide_t'(delta_q);
        lane1_b = wide_t'(w_sel);
      end
      default: ;
    endcase
    lane1_p = lane1_a * lane1_b;
    lane1_s = sat(lane1_p >>> FRAC_W);

    if (state_q == S_UPDATE) begin
      lane2_a = wide_t'(step_q);
      lane2_b = wide_t'(dend_sel);
    end else begin
      lane2_a = wide_t'(ratio_q);
      lane2_b = wide_t'(lane1_s);
    end
    lane2_p = lane2_a * lane2_b;
    lane2_s = sat(lane2_p >>> FRAC_W);
    w_sum   = wide_t'(w_sel) + (lane2_p >>> FRAC_W);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dend_d   = dend_q;
    w_d      = w_q;
    axon_d   = axon_q;
    bp_d     = bp_q;
    ratio_d  = ratio_q;
    d_d      = d_q;
    delta_d  = delta_q;
    step_d   = step_q;
    change_d = change_q;
    w_new_d  = w_new_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          dend_d  = bus.dendrites;
          w_d     = bus.weights;
          axon_d  = bus.axon;
          bp_d    = bus.backprop;
          ratio_d = bus.training_ratio;
          idx_d   = '0;
          state_d = S_DERIV;
        end
      end
      S_DERIV: begin
        d_d     = lane1_s;
        state_d = S_DELTA;
      end
      S_DELTA: begin
        delta_d = lane1_s;
        step_d  = lane2_s;
        idx_d   = '0;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        for (int i = 0; i < N_INPUTS; i++) begin
          if (idx_q == IDX_W'(i)) change_d[i] = lane1_s;
        end
        for (int i = 0; i <= N_INPUTS; i++) begin
          if (idx_q == IDX_W'(i)) w_new_d[i] = sat(w_sum);
        end
        if (idx_q == IDX_W'(N_INPUTS)) state_d = S_DONE;
        else                           idx_d   = idx_q + IDX_W'(1);
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      dend_q   <= '0;
      w_q      <= '0;
      axon_q   <= '0;
      bp_q     <= '0;
      ratio_q  <= '0;
      d_q      <= '0;
      delta_q  <= '0;
      step_q   <= '0;
      change_q <= '0;
      w_new_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dend_q   <= dend_d;
      w_q      <= w_d;
      axon_q   <= axon_d;
      bp_q     <= bp_d;
      ratio_q  <= ratio_d;
      d_q      <= d_d;
      delta_q  <= delta_d;
      step_q   <= step_d;
      change_q <= change_d;
      w_new_q  <= w_new_d;
    end
  end

  assign bus.in_ready        = (state_q == S_IDLE);
  assign bus.out_valid       = (state_q == S_DONE);
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.backprop_change = change_q;
  assign bus.weights_new     = w_new_q;
endmodule

// File: tb/tb_backprop_seq_engine.sv
// Directed bench for backprop_seq_engine: N_INPUTS=32 instance for function/stall/reset,
// N_INPUTS=4 instance for back-to-back spacing.
module tb_backprop_seq_engine;
  logic clk = 1'b0;
  logic rst;
  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  backprop_seq_if #(.N_INPUTS(32), .DATA_W(16)) bus32();
  backprop_seq_if #(.N_INPUTS(4),  .DATA_W(16)) bus4();

  backprop_seq_engine #(.N_INPUTS(32), .DATA_W(16), .FRAC_W(12)) u_dut32 (
    .clk(clk), .rst(rst), .bus(bus32)
  );
  backprop_seq_engine #(.N_INPUTS(4), .DATA_W(16), .FRAC_W(12)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  longint m_dend[33], m_w[33], m_axon, m_bp, m_ratio;
  longint exp_chg[33], exp_wn[33];

  function automatic longint sat16(longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic check_eq(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Q4.12 reference built straight from the arithmetic definition.
  task automatic model(input int n);
    longint d, delta, step;
    d     = sat16((m_axon * (4096 - m_axon)) >>> 12);
    delta = sat16((m_bp * d) >>> 12);
    step  = sat16((m_ratio * delta) >>> 12);
    for (int i = 0; i < n; i++) begin
      exp_chg[i] = sat16((delta * m_w[i]) >>> 12);
      exp_wn[i]  = sat16(m_w[i] + ((step * m_dend[i]) >>> 12));
    end
    exp_wn[n] = sat16(m_w[n] + step);
  endtask

  task automatic clear_vec();
    for (int i = 0; i < 33; i++) begin
      m_dend[i] = 0;
      m_w[i]    = 0;
    end
  endtask

  function automatic longint chg32(int i);
    return longint'($signed(bus32.backprop_change[i*16 +: 16]));
  endfunction
  function automatic longint wn32(int i);
    return longint'($signed(bus32.weights_new[i*16 +: 16]));
  endfunction
  function automatic longint chg4(int i);
    return longint'($signed(bus4.backprop_change[i*16 +: 16]));
  endfunction
  function automatic longint wn4(int i);
    return longint'($signed(bus4.weights_new[i*16 +: 16]));
  endfunction

  task automatic drive32();
    for (int i = 0; i < 32; i++) bus32.dendrites[i*16 +: 16] = 16'(m_dend[i]);
    for (int i = 0; i < 33; i++) bus32.weights[i*16 +: 16]   = 16'(m_w[i]);
    bus32.axon           = 16'(m_axon);
    bus32.backprop       = 16'(m_bp);
    bus32.training_ratio = 16'(m_ratio);
  endtask

  task automatic drive4();
    for (int i = 0; i < 4; i++) bus4.dendrites[i*16 +: 16] = 16'(m_dend[i]);
    for (int i = 0; i < 5; i++) bus4.weights[i*16 +: 16]   = 16'(m_w[i]);
    bus4.axon           = 16'(m_axon);
    bus4.backprop       = 16'(m_bp);
    bus4.training_ratio = 16'(m_ratio);
  endtask

  task automatic junk32();
    for (int i = 0; i < 32; i++) bus32.dendrites[i*16 +: 16] = 16'($urandom);
    for (int i = 0; i < 33; i++) bus32.weights[i*16 +: 16]   = 16'($urandom);
    bus32.axon           = 16'($urandom);
    bus32.backprop       = 16'($urandom);
    bus32.training_ratio = 16'($urandom);
  endtask

  // One job on the 32-input engine; stall = cycles to hold out_ready low in DONE.
  task automatic run_job32(string tag, int stall);
    bit ok;
    int lat;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus32.in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check_eq({tag, "_ready"}, longint'(ok), 1);
    model(32);
    drive32();
    bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    junk32();
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (bus32.out_valid) begin lat = k; break; end
      bus32.out_ready = (k == 3);
    end
    bus32.out_ready = 1'b0;
    bus32.in_valid  = 1'b0;
    check_eq({tag, "_latency"}, lat, 35);
    for (int s = 0; s < stall; s++) begin
      bus32.in_valid = s[0];
      @(posedge clk); #1;
      check_eq($sformatf("%s_stall%0d_vld", tag, s), longint'(bus32.out_valid), 1);
      check_eq($sformatf("%s_stall%0d_rdy", tag, s), longint'(bus32.in_ready), 0);
      check_eq($sformatf("%s_stall%0d_wn0", tag, s), wn32(0), exp_wn[0]);
    end
    bus32.in_valid = 1'b0;
    for (int i = 0; i < 32; i++) check_eq($sformatf("%s_chg%0d", tag, i), chg32(i), exp_chg[i]);
    for (int i = 0; i < 33; i++) check_eq($sformatf("%s_wn%0d", tag, i), wn32(i), exp_wn[i]);
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
    check_eq({tag, "_idle_rdy"}, longint'(bus32.in_ready), 1);
    check_eq({tag, "_idle_vld"}, longint'(bus32.out_valid), 0);
    check_eq({tag, "_idle_busy"}, longint'(bus32.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit ok;
    int lat, acc, prev_acc;
    rst = 1'b1;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
    bus4.in_valid  = 1'b0; bus4.out_ready  = 1'b1;
    clear_vec(); m_axon = 0; m_bp = 0; m_ratio = 0;
    drive32(); drive4();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("reset_rdy",  longint'(bus32.in_ready), 1);
    check_eq("reset_vld",  longint'(bus32.out_valid), 0);
    check_eq("reset_busy", longint'(bus32.busy), 0);
    check_eq("reset_chg_nonzero", longint'(|bus32.backprop_change), 0);
    check_eq("reset_wn_nonzero",  longint'(|bus32.weights_new), 0);

    // Nominal positive and negative error.
    clear_vec(); m_dend[0] = 4096; m_w[0] = 2048; m_axon = 2048; m_bp = 4096; m_ratio = 2048;
    run_job32("t1", 0);
    check_eq("t1_hand_chg0", chg32(0), 512);
    check_eq("t1_hand_wn0",  wn32(0), 2560);
    check_eq("t1_hand_wn32", wn32(32), 512);

    m_bp = -4096;
    run_job32("t2", 10);
    check_eq("t2_hand_chg0", chg32(0), -512);
    check_eq("t2_hand_wn0",  wn32(0), 1536);
    check_eq("t2_hand_wn32", wn32(32), -512);

    // Saturation both ways.
    clear_vec(); m_dend[0] = 32767; m_w[0] = 32767; m_axon = 2048; m_bp = 32767; m_ratio = 32767;
    run_job32("t3p", 0);
    check_eq("t3p_hand_wn0",  wn32(0), 32767);
    check_eq("t3p_hand_wn32", wn32(32), 32767);
    clear_vec(); m_dend[0] = 32767; m_w[0] = -32768; m_axon = 2048; m_bp = -32768; m_ratio = 32767;
    run_job32("t3n", 0);
    check_eq("t3n_hand_wn0",  wn32(0), -32768);
    check_eq("t3n_hand_wn32", wn32(32), -32768);

    // Reset while UPDATE is at idx 5.
    clear_vec(); m_dend[0] = 4096; m_w[0] = 2048; m_axon = 2048; m_bp = -4096; m_ratio = 2048;
    drive32();
    bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check_eq("t5_busy_before", longint'(bus32.busy), 1);
    check_eq("t5_partial_chg0", chg32(0), -512);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("t5_rdy",  longint'(bus32.in_ready), 1);
    check_eq("t5_vld",  longint'(bus32.out_valid), 0);
    check_eq("t5_busy", longint'(bus32.busy), 0);
    check_eq("t5_chg_nonzero", longint'(|bus32.backprop_change), 0);
    check_eq("t5_wn_nonzero",  longint'(|bus32.weights_new), 0);
    run_job32("t5b", 0);

    // Back-to-back on the 4-input engine: DERIV+DELTA+5 UPDATE+DONE+IDLE = 9 edges apart.
    prev_acc = 0;
    for (int j = 0; j < 3; j++) begin
      clear_vec();
      for (int i = 0; i < 5; i++) m_w[i] = j*1000 + i*700 - 1500;
      for (int i = 0; i < 4; i++) m_dend[i] = 2000 - i*900 + j*300;
      m_axon = 1000 + j*1200; m_bp = -3000 + j*2500; m_ratio = 3000 - j*500;
      model(4);
      drive4();
      bus4.in_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        if (bus4.in_ready) begin ok = 1'b1; break; end
        @(posedge clk); #1;
      end
      check_eq($sformatf("t6_ready%0d", j), longint'(ok), 1);
      @(posedge clk); #1;
      acc = int'(cyc);
      if (j > 0) check_eq($sformatf("t6_spacing%0d", j), acc - prev_acc, 9);
      prev_acc = acc;
      lat = 0;
      for (int k = 1; k <= 50; k++) begin
        @(posedge clk); #1;
        if (bus4.out_valid) begin lat = k; break; end
      end
      check_eq($sformatf("t6_latency%0d", j), lat, 7);
      for (int i = 0; i < 4; i++) check_eq($sformatf("t6_j%0d_chg%0d", j, i), chg4(i), exp_chg[i]);
      for (int i = 0; i < 5; i++) check_eq($sformatf("t6_j%0d_wn%0d", j, i), wn4(i), exp_wn[i]);
    end
    bus4.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
